// File: rtl/ibex_efpga_pkg.sv
// Shared types for the Ibex <-> eFPGA bridge: FSM state encoding, operator encoding
// and the default WAIT-state cycle budget.
package ibex_efpga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } efpga_state_e;

  // Operator encoding shared with ibex_eFPGA; the bridge only latches and forwards it.
  typedef enum logic [1:0] {
    EFPGA_OP_0 = 2'd0,
    EFPGA_OP_1 = 2'd1,
    EFPGA_OP_2 = 2'd2,
    EFPGA_OP_3 = 2'd3
  } efpga_op_e;

  localparam logic [15:0] EFPGA_TIMEOUT_DEFAULT = 16'd1024;

endpackage

// File: rtl/ibex_efpga_timeout_ctr.sv
// WAIT-state watchdog for the eFPGA bridge. Counts ticks since the last clear and
// flags expiry on the tick that sees the count at Limit-1.
module ibex_efpga_timeout_ctr #(
  parameter logic [15:0] Limit = 16'd1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic tick_i,
  output logic expire_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= 16'd0;
    end else if (tick_i) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign expire_o = tick_i && (cnt_q == (Limit - 16'd1));

endmodule

// File: rtl/ibex_efpga_bridge.sv
// Bridge between the Ibex EX stage and the eFPGA fabric: latches operands, pulses start,
// captures three results and holds done until en_i drops. Macro IBEX_EFPGA_TIMEOUT_EN adds a WAIT watchdog.
module ibex_efpga_bridge
  import ibex_efpga_pkg::*;
#(
  parameter logic [15:0] TimeoutCycles = EFPGA_TIMEOUT_DEFAULT,
  parameter logic [31:0] ErrData       = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        write_strobe_i,
  input  logic [1:0]  operator_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  output logic        fab_start_o,
  output logic [1:0]  fab_operator_o,
  output logic [31:0] fab_op_a_o,
  output logic [31:0] fab_op_b_o,
  input  logic        fab_valid_i,
  input  logic [31:0] fab_result_a_i,
  input  logic [31:0] fab_result_b_i,
  input  logic [31:0] fab_result_c_i,
  output logic [31:0] result_a_o,
  output logic [31:0] result_b_o,
  output logic [31:0] result_c_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [1:0]  state_o
);

  // Handshake: write_strobe_i is accepted only in IDLE; fab_valid_i is a single-cycle
  // qualifier honoured only in WAIT; done_o stays high in HOLD until en_i is sampled low.

  efpga_state_e state_q;
  efpga_op_e    op_q;
  logic         err_q;
  logic         timeout_expire;

`ifdef IBEX_EFPGA_TIMEOUT_EN
  ibex_efpga_timeout_ctr #(
    .Limit(TimeoutCycles)
  ) u_timeout_ctr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (state_q != WAIT),
    .tick_i   (state_q == WAIT),
    .expire_o (timeout_expire)
  );
`else
  logic [15:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TimeoutCycles;
  assign timeout_expire        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      op_q        <= EFPGA_OP_0;
      fab_start_o <= 1'b0;
      fab_op_a_o  <= 32'h0;
      fab_op_b_o  <= 32'h0;
      result_a_o  <= 32'h0;
      result_b_o  <= 32'h0;
      result_c_o  <= 32'h0;
      done_o      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      fab_start_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (write_strobe_i) begin
            state_q     <= ISSUE;
            fab_start_o <= 1'b1;
            op_q        <= efpga_op_e'(operator_i);
            fab_op_a_o  <= operand_a_i;
            fab_op_b_o  <= operand_b_i;
          end
        end
        ISSUE: begin
          state_q <= en_i ? WAIT : IDLE;
        end
        WAIT: begin
          // Abort beats capture; capture beats a coincident timeout.
          if (!en_i) begin
            state_q <= IDLE;
          end else if (fab_valid_i) begin
            state_q    <= HOLD;
            result_a_o <= fab_result_a_i;
            result_b_o <= fab_result_b_i;
            result_c_o <= fab_result_c_i;
            done_o     <= 1'b1;
          end else if (timeout_expire) begin
            state_q    <= HOLD;
            result_a_o <= ErrData;
            result_b_o <= ErrData;
            result_c_o <= ErrData;
            done_o     <= 1'b1;
            err_q      <= 1'b1;
          end
        end
        HOLD: begin
          if (!en_i) begin
            state_q <= IDLE;
            done_o  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fab_operator_o = op_q;
  assign busy_o         = (state_q != IDLE);
  assign err_o          = err_q;
  assign state_o        = state_q;

endmodule
